bcd_xs3_conv: RTL and testbench

BCD_XS3_CONV -- requirements
Module: bcd_xs3_conv

---
 rtl/bcd_xs3_conv_pkg.sv | 26 ++
 rtl/bcd_xs3_conv_digit.sv | 38 +++
 rtl/bcd_xs3_conv.sv | 116 +++++++++++
 tb/tb_bcd_xs3_conv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_conv_pkg.sv
// code_conv_pkg: shared mode/state encodings and constants for bcd_xs3_conv.
// Rev 1.0
`default_nettype none

package code_conv_pkg;

  typedef enum logic [1:0] {
    MODE_BCD2XS3   = 2'b00,
    MODE_XS32BCD   = 2'b01,
    MODE_BCD2AIKEN = 2'b10,
    MODE_PASS      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [3:0] XS3_OFS       = 4'd3;
  localparam logic [3:0] AIKEN_OFS     = 4'd6;
  localparam logic [3:0] INVALID_DIGIT = 4'hF;

endpackage

`default_nettype wire

// File: rtl/bcd_xs3_conv_digit.sv
// code_conv_digit: combinational single-digit code converter with invalid flag.
// Rev 1.0
`default_nettype none

module code_conv_digit
  import code_conv_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [1:0] mode,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = digit;
    invalid = 1'b0;
    case (mode_e'(mode))
      MODE_BCD2XS3: begin
        if (digit > 4'd9) invalid = 1'b1;
        else              code = digit + XS3_OFS;
      end
      MODE_XS32BCD: begin
        if (digit < XS3_OFS || digit > 4'd12) invalid = 1'b1;
        else                                  code = digit - XS3_OFS;
      end
      MODE_BCD2AIKEN: begin
        if (digit > 4'd9)      invalid = 1'b1;
        else if (digit > 4'd4) code = digit + AIKEN_OFS;
      end
      default: ;
    endcase
    // An invalid digit always reports the reserved code, regardless of mode.
    if (invalid) code = INVALID_DIGIT;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_xs3_conv.sv
// bcd_xs3_conv: digit-serial BCD/XS-3/Aiken word converter with valid/ready handshakes.
// Optional saturating error counter via BCD_XS3_CONV_ERRCNT_EN. Rev 1.0
`default_nettype none

module bcd_xs3_conv
  import code_conv_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic [NDIG-1:0]   out_err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e            state, state_nx;
  logic [4*NDIG-1:0] src_q, acc_q, acc_nx;
  logic [NDIG-1:0]   err_acc_q, err_acc_nx;
  logic [1:0]        mode_q;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        cur_digit, cur_code;
  logic              cur_inv;
  logic              accept, release_out, last_digit;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;
  assign last_digit  = (idx == IDX_W'(NDIG - 1));
  assign cur_digit   = src_q[idx*4 +: 4];

  code_conv_digit u_digit (
    .digit   (cur_digit),
    .mode    (mode_q),
    .code    (cur_code),
    .invalid (cur_inv)
  );

  always_comb begin
    acc_nx              = acc_q;
    err_acc_nx          = err_acc_q;
    acc_nx[idx*4 +: 4]  = cur_code;
    err_acc_nx[idx]     = cur_inv;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)     state_nx = CONV;
      CONV:    if (last_digit) state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      mode_q    <= '0;
      idx       <= '0;
      acc_q     <= '0;
      err_acc_q <= '0;
      out_data  <= '0;
      out_err   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        src_q  <= in_data;
        mode_q <= in_mode;
        idx    <= '0;
      end
      if (state == CONV) begin
        acc_q     <= acc_nx;
        err_acc_q <= err_acc_nx;
        idx       <= last_digit ? '0 : idx + 1'b1;
        // Outputs only change once the whole word is converted.
        if (last_digit) begin
          out_data <= acc_nx;
          out_err  <= err_acc_nx;
        end
      end
    end
  end

`ifdef BCD_XS3_CONV_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (release_out && (|out_err) && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_release;
  assign unused_release = release_out;
  assign err_cnt        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_xs3_conv.sv
// tb_bcd_xs3_conv: directed self-checking bench for bcd_xs3_conv (NDIG=4).
// Rev 1.0
`default_nettype none

module tb_bcd_xs3_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [15:0] out_data, out_data2;
  logic [3:0]  out_err, out_err2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int errors = 0;
  int checks = 0;
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;

`ifdef BCD_XS3_CONV_ERRCNT_EN
  bit cnt_en = 1'b1;
`else
  bit cnt_en = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_xs3_conv #(.NDIG(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  bcd_xs3_conv #(.NDIG(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
    .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_word(input string tag, input logic [15:0] data, input logic [1:0] mode,
                          input logic [15:0] exp_data, input logic [3:0] exp_err);
    int lat;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = data;
    in_mode   = mode;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    in_mode  = ~mode;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    chk({tag, "_data2"}, 32'(out_data2), 32'(exp_data));
    @(posedge clk); #1;
    if (cnt_en && exp_err != 4'd0) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3)   exp_cnt2++;
    end
    chk({tag, "_vld_off"}, 32'(out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt8));
    chk({tag, "_cnt2"}, 32'(err_cnt2), 32'(exp_cnt2));
  endtask

  initial begin
    logic [15:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    chk("rst_cnt",   32'(err_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    run_word("bcd2xs3",     16'h1209, 2'b00, 16'h453C, 4'b0000);
    run_word("bcd2xs3_bad", 16'h9A00, 2'b00, 16'hCF33, 4'b0100);
    run_word("xs32bcd",     16'hC3A2, 2'b01, 16'h907F, 4'b0001);
    run_word("xs32bcd_ends",16'hFC30, 2'b01, 16'hF90F, 4'b1001);
    // Digit 9 is legal in Aiken and maps to F; digit A is the invalid one.
    run_word("aiken",       16'h5904, 2'b10, 16'hBF04, 4'b0000);
    run_word("aiken_bad",   16'h5A04, 2'b10, 16'hBF04, 4'b0100);
    run_word("pass",        16'hFA50, 2'b11, 16'hFA50, 4'b0000);

    // Backpressure in DONE: outputs hold, new input ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0123;
    in_mode   = 2'b00;
    @(posedge clk); #1;
    in_data = 16'h9999;
    in_mode = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", 32'(out_valid), 32'd1);
    held = out_data;
    chk("bp_data0", 32'(out_data), 32'h3456);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data",  32'(out_data),  32'(held));
      chk("bp_hold_rdy",   32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rdy",   32'(in_ready),  32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Saturation of the narrow counter over several erroneous words.
    for (int i = 0; i < 3; i++)
      run_word("sat", 16'hAAAA, 2'b00, 16'hFFFF, 4'b1111);

    // Reset in mid-conversion abandons the word.
    in_valid = 1'b1;
    in_data  = 16'hBBBB;
    in_mode  = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    chk("midrst_cnt",   32'(err_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_out", 32'(out_valid), 32'd0);
    end
    chk("midrst_cnt_after", 32'(err_cnt), 32'd0);
    run_word("after_rst", 16'h0987, 2'b00, 16'h3CBA, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
